// File: rtl/int_scoreboard.sv
// Integer register scoreboard: tracks registers with outstanding long-latency
// writes and raises a stall for RAW/WAW hazards of the instruction in ID.
module int_scoreboard #(
  parameter int reg_els_p        = 32,
  parameter int reg_addr_width_p = 5
) (
  input  logic                        clk_i,
  input  logic                        reset_i,
  input  logic                        op_reads_rf1_i,
  input  logic                        op_reads_rf2_i,
  input  logic                        op_writes_rf_i,
  input  logic [reg_addr_width_p-1:0] src1_id_i,
  input  logic [reg_addr_width_p-1:0] src2_id_i,
  input  logic [reg_addr_width_p-1:0] dest_id_i,
  input  logic                        score_i,
  input  logic [reg_addr_width_p-1:0] score_id_i,
  input  logic                        clear_i,
  input  logic [reg_addr_width_p-1:0] clear_id_i,
  output logic                        dependency_o,
  output logic [reg_addr_width_p:0]   pending_count_o,
  output logic                        empty_o,
  output logic                        error_o
);

  localparam int cnt_w = reg_addr_width_p + 1;

  logic [reg_els_p-1:0] pending_q, pending_d;
  logic [cnt_w-1:0]     count_q, count_d;
  logic                 error_q, error_d;
  logic                 score_hit, same_id;
  logic                 busy_rs1, busy_rs2, busy_rd;

  always_comb begin
    // NOTE: every variable written here gets a default first, so no path
    // through the block leaves a value unassigned and no latch is inferred.
    pending_d = pending_q;
    error_d   = error_q;
    count_d   = '0;
    score_hit = score_i && (score_id_i != '0);
    same_id   = clear_i && score_hit && (score_id_i == clear_id_i);

    if (clear_i && !pending_q[clear_id_i] && !same_id) error_d = 1'b1;
    if (score_hit && pending_q[score_id_i] && !same_id) error_d = 1'b1;

    // Score is applied after clear so that it wins on a same-id collision.
    if (clear_i)   pending_d[clear_id_i] = 1'b0;
    if (score_hit) pending_d[score_id_i] = 1'b1;

    for (int i = 0; i < reg_els_p; i++) begin
      count_d = count_d + cnt_w'(pending_d[i]);
    end
  end

  // A register being written back this cycle is released with zero latency.
  assign busy_rs1 = (src1_id_i != '0) && pending_q[src1_id_i]
                    && !(clear_i && (clear_id_i == src1_id_i));
  assign busy_rs2 = (src2_id_i != '0) && pending_q[src2_id_i]
                    && !(clear_i && (clear_id_i == src2_id_i));
  assign busy_rd  = (dest_id_i != '0) && pending_q[dest_id_i]
                    && !(clear_i && (clear_id_i == dest_id_i));

  assign dependency_o = (op_reads_rf1_i && busy_rs1)
                      | (op_reads_rf2_i && busy_rs2)
                      | (op_writes_rf_i && busy_rd);

  always_ff @(posedge clk_i) begin
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge values, independent of statement order.
    if (reset_i) begin
      pending_q <= '0;
      count_q   <= '0;
      error_q   <= 1'b0;
    end else begin
      pending_q <= pending_d;
      count_q   <= count_d;
      error_q   <= error_d;
    end
  end

  assign pending_count_o = count_q;
  assign empty_o         = (count_q == '0);
  assign error_o         = error_q;

endmodule

// File: tb/tb_int_scoreboard.sv
// Directed bench for int_scoreboard: a reference model pushes expected results
// into a queue as each step is driven; they are popped when the DUT responds.
module tb_int_scoreboard;

  logic       clk_i = 1'b0;
  logic       reset_i;
  logic       op_reads_rf1_i, op_reads_rf2_i, op_writes_rf_i;
  logic [4:0] src1_id_i, src2_id_i, dest_id_i;
  logic       score_i, clear_i;
  logic [4:0] score_id_i, clear_id_i;
  logic       dependency_o;
  logic [5:0] pending_count_o;
  logic       empty_o;
  logic       error_o;

  int_scoreboard dut (
    .clk_i           (clk_i),
    .reset_i         (reset_i),
    .op_reads_rf1_i  (op_reads_rf1_i),
    .op_reads_rf2_i  (op_reads_rf2_i),
    .op_writes_rf_i  (op_writes_rf_i),
    .src1_id_i       (src1_id_i),
    .src2_id_i       (src2_id_i),
    .dest_id_i       (dest_id_i),
    .score_i         (score_i),
    .score_id_i      (score_id_i),
    .clear_i         (clear_i),
    .clear_id_i      (clear_id_i),
    .dependency_o    (dependency_o),
    .pending_count_o (pending_count_o),
    .empty_o         (empty_o),
    .error_o         (error_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    string      tag;
    logic       dep;
    logic [5:0] cnt;
    logic       emp;
    logic       err;
  } exp_t;

  exp_t        exp_q[$];
  logic [31:0] m_pend;
  logic        m_err;
  int          checks = 0;
  int          errors = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic m_busy(input logic [4:0] id);
    return (id != 5'd0) && m_pend[id] && !(clear_i && clear_id_i == id);
  endfunction

  task automatic idle();
    reset_i = 1'b0;
    op_reads_rf1_i = 1'b0; op_reads_rf2_i = 1'b0; op_writes_rf_i = 1'b0;
    src1_id_i = '0; src2_id_i = '0; dest_id_i = '0;
    score_i = 1'b0; score_id_i = '0;
    clear_i = 1'b0; clear_id_i = '0;
  endtask

  // Predict, push, then advance one clock and compare against the popped entry.
  task automatic cycle(input string tag);
    exp_t e;
    e.tag = tag;
    e.dep = (op_reads_rf1_i && m_busy(src1_id_i)) ||
            (op_reads_rf2_i && m_busy(src2_id_i)) ||
            (op_writes_rf_i && m_busy(dest_id_i));
    if (reset_i) begin
      m_pend = '0;
      m_err  = 1'b0;
    end else begin
      if (clear_i && !m_pend[clear_id_i] &&
          !(score_i && score_id_i == clear_id_i && score_id_i != 0)) m_err = 1'b1;
      if (score_i && score_id_i != 0 && m_pend[score_id_i] &&
          !(clear_i && clear_id_i == score_id_i)) m_err = 1'b1;
      if (clear_i) m_pend[clear_id_i] = 1'b0;
      if (score_i && score_id_i != 0) m_pend[score_id_i] = 1'b1;
    end
    e.cnt = 6'($countones(m_pend));
    e.emp = (e.cnt == 0);
    e.err = m_err;
    exp_q.push_back(e);

    @(negedge clk_i);
    check({exp_q[0].tag, ".dep"}, 32'(dependency_o), 32'(exp_q[0].dep));
    @(posedge clk_i);
    #1;
    e = exp_q.pop_front();
    check({e.tag, ".cnt"}, 32'(pending_count_o), 32'(e.cnt));
    check({e.tag, ".emp"}, 32'(empty_o), 32'(e.emp));
    check({e.tag, ".err"}, 32'(error_o), 32'(e.err));
  endtask

  initial begin
    idle();
    reset_i = 1'b1;
    m_pend = '0;
    m_err  = 1'b0;
    repeat (2) @(posedge clk_i);
    #1;

    // Reset state: no dependency for any inputs while held in reset.
    reset_i = 1'b1; op_reads_rf1_i = 1'b1; op_reads_rf2_i = 1'b1; op_writes_rf_i = 1'b1;
    src1_id_i = 5'd5; src2_id_i = 5'd31; dest_id_i = 5'd1;
    score_i = 1'b1; score_id_i = 5'd6; clear_i = 1'b1; clear_id_i = 5'd2;
    cycle("reset");

    // Score x5, then RAW on rs1.
    idle(); score_i = 1'b1; score_id_i = 5'd5; cycle("score5");
    idle(); op_reads_rf1_i = 1'b1; src1_id_i = 5'd5; cycle("raw_rs1");

    // Clear bypass on rs2.
    idle(); clear_i = 1'b1; clear_id_i = 5'd5; op_reads_rf2_i = 1'b1; src2_id_i = 5'd5;
    cycle("clear_bypass");

    // Same-id score and clear: score wins, no error.
    idle(); score_i = 1'b1; score_id_i = 5'd7; cycle("score7");
    idle(); score_i = 1'b1; score_id_i = 5'd7; clear_i = 1'b1; clear_id_i = 5'd7;
    op_reads_rf1_i = 1'b1; src1_id_i = 5'd7; cycle("same_id");
    idle(); op_reads_rf1_i = 1'b1; src1_id_i = 5'd7; cycle("x7_still");

    // Scoring does not stall in the same cycle.
    idle(); score_i = 1'b1; score_id_i = 5'd3; op_reads_rf1_i = 1'b1; src1_id_i = 5'd3;
    cycle("score_nobypass");

    // Different-id score and clear together.
    idle(); score_i = 1'b1; score_id_i = 5'd8; clear_i = 1'b1; clear_id_i = 5'd3;
    op_reads_rf2_i = 1'b1; src2_id_i = 5'd8; cycle("diff_id");
    idle(); op_reads_rf2_i = 1'b1; src2_id_i = 5'd8; op_writes_rf_i = 1'b1; dest_id_i = 5'd3;
    cycle("after_diff");

    // x0 is never pending and never stalls.
    idle(); score_i = 1'b1; score_id_i = 5'd0; cycle("score_x0");
    idle(); op_reads_rf1_i = 1'b1; op_writes_rf_i = 1'b1; cycle("read_x0");

    // Clear of a non-pending register is a sticky error.
    idle(); clear_i = 1'b1; clear_id_i = 5'd9; cycle("clear9_err");
    idle(); cycle("err_sticky");
    idle(); score_i = 1'b1; score_id_i = 5'd12; cycle("err_sticky2");
    idle(); reset_i = 1'b1; cycle("reset2");

    // Fill x1..x31, WAW on x31, then reset mid-stream.
    for (int i = 1; i < 32; i++) begin
      idle(); score_i = 1'b1; score_id_i = 5'(i); cycle($sformatf("fill%0d", i));
    end
    idle(); op_writes_rf_i = 1'b1; dest_id_i = 5'd31; cycle("waw31");
    idle(); op_reads_rf1_i = 1'b1; src1_id_i = 5'd0; cycle("full_x0");
    idle(); reset_i = 1'b1; score_i = 1'b1; score_id_i = 5'd4; cycle("mid_reset");
    idle(); op_writes_rf_i = 1'b1; dest_id_i = 5'd31; op_reads_rf1_i = 1'b1; src1_id_i = 5'd4;
    cycle("post_reset");

    // Double score of a pending register is an error.
    idle(); score_i = 1'b1; score_id_i = 5'd2; cycle("score2");
    idle(); score_i = 1'b1; score_id_i = 5'd2; cycle("dup_score");

    check("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: observed no completion expected completion");
    $fatal(1, "timeout");
  end

endmodule
